// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI/HDMI pixel-clock generator: FSM state
// encoding, ring-register operations and the default bits-per-pixel ratio.
package dvi_pkg;

  // TMDS links carry 10 bits per pixel.
  localparam int DVI_CLK_RATIO_DEFAULT = 10;

  // Top-level run/stop state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } dvi_state_e;

  // What the ring register does on the next clk_x5 edge.
  typedef enum logic [2:0] {
    RING_CLEAR = 3'd0,
    RING_LOAD  = 3'd1,
    RING_ROT1  = 3'd2,
    RING_ROT2  = 3'd3,
    RING_ROT3  = 3'd4
  } ring_op_e;

endpackage

// File: rtl/ddr_out.sv
// Double-data-rate output cell. Both bits are captured on the rising edge;
// i_d_rise is driven while clk is high and i_d_fall while clk is low, so the
// pair appears on o_q one clk cycle after capture. Reset drives o_q low.
module ddr_out (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_e,
  input  logic i_d_rise,
  input  logic i_d_fall,
  output logic o_q
);

  logic r_rise;
  logic r_fall;

  // Capture both half-cycle bits together; hold them while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_e) begin
      r_rise <= i_d_rise;
      r_fall <= i_d_fall;
    end
  end

  assign o_q = i_clk ? r_rise : r_fall;

endmodule

// File: rtl/dvi_clock_ring.sv
// Pixel-clock pattern ring. Holds one pixel period of bits; bit 0 goes out
// in the clk high half and bit 1 in the low half. Each cycle the ring is
// cleared, loaded with the start pattern, or rotated right by 1, 2 or 3 bits
// (2 = nominal, 1/3 = one-bit phase retard/advance). Also registers the
// pix_start strobe alongside the ring and reports whether a nominal rotation
// would begin a new high half, which the stop logic uses to end cleanly.
module dvi_clock_ring
  import dvi_pkg::*;
#(
  parameter int RATIO = DVI_CLK_RATIO_DEFAULT
) (
  input  logic     clk_x5,
  input  logic     rst_n_x5,
  input  ring_op_e i_op,
  output logic     o_bit0,
  output logic     o_bit1,
  output logic     o_pix_start,
  output logic     o_rise_on_rot2
);

  // Ones at the LSBs so the first bits out are the high half.
  localparam logic [RATIO-1:0] LOAD_PAT = {{(RATIO/2){1'b0}}, {(RATIO/2){1'b1}}};

  logic [RATIO-1:0] r_ring;
  logic             r_pix_start;
  logic [RATIO-1:0] w_rot1;
  logic [RATIO-1:0] w_rot2;
  logic [RATIO-1:0] w_rot3;
  logic [RATIO-1:0] w_next;

  assign w_rot1 = {r_ring[0],   r_ring[RATIO-1:1]};
  assign w_rot2 = {r_ring[1:0], r_ring[RATIO-1:2]};
  assign w_rot3 = {r_ring[2:0], r_ring[RATIO-1:3]};

  // Select the next ring contents for the requested operation.
  always_comb begin
    w_next = '0;
    case (i_op)
      RING_LOAD: w_next = LOAD_PAT;
      RING_ROT1: w_next = w_rot1;
      RING_ROT2: w_next = w_rot2;
      RING_ROT3: w_next = w_rot3;
      default:   w_next = '0;
    endcase
  end

  // A rising edge lies either between the last bit sent (current bit 1) and
  // the new bit 0, or between the new bit 0 and bit 1.
  assign o_rise_on_rot2 = (~r_ring[1] & w_rot2[0]) | (~w_rot2[0] & w_rot2[1]);

  // Ring register and its aligned pix_start strobe.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_ring      <= '0;
      r_pix_start <= 1'b0;
    end else begin
      r_ring      <= w_next;
      r_pix_start <= (~r_ring[1] & w_next[0]) | (~w_next[0] & w_next[1]);
    end
  end

  assign o_bit0      = r_ring[0];
  assign o_bit1      = r_ring[1];
  assign o_pix_start = r_pix_start;

endmodule

// File: rtl/dvi_clock_gen.sv
// DVI/HDMI pixel-clock generator on the half-rate bit clock clk_x5.
// Drives N_CLK pseudo-differential qp/qn pairs through DDR cells from one
// shared RATIO-bit pattern ring, with glitch-free start/stop and a
// pix_start strobe marking each pixel period for sibling serialisers.
// RATIO must be even and 4..32; PH_W must satisfy 2**PH_W >= RATIO.
// Build option DVI_CLOCK_GEN_PHASE_ADJ_EN adds one-bit phase stepping
// (phase_step/phase_dir), a one-pixel cooldown (phase_busy) and the
// cumulative phase_offset; without it those inputs are ignored and the
// phase outputs are tied to zero.
module dvi_clock_gen
  import dvi_pkg::*;
#(
  parameter int RATIO = DVI_CLK_RATIO_DEFAULT,
  parameter int N_CLK = 1,
  parameter int PH_W  = 5
) (
  input  logic             clk_x5,
  input  logic             rst_n_x5,
  input  logic             en,
  output logic             running,
  output logic             pix_start,
  input  logic             phase_step,
  input  logic             phase_dir,
  output logic             phase_busy,
  output logic [PH_W-1:0]  phase_offset,
  output logic [N_CLK-1:0] qp,
  output logic [N_CLK-1:0] qn
);

  dvi_state_e r_state;
  dvi_state_e w_state_nxt;
  ring_op_e   w_ring_op;
  logic       w_accept;
  logic       w_dir;
  logic       w_rise_on_rot2;
  logic       w_bit0;
  logic       w_bit1;

  // Run/stop state register.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and ring operation. STOPPING keeps rotating until the next
  // rotation would start a new high half, so the last high and low halves
  // always complete; en returning in STOPPING resumes without a seam.
  always_comb begin
    w_state_nxt = r_state;
    w_ring_op   = RING_CLEAR;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_ring_op   = RING_LOAD;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_ring_op = w_dir ? RING_ROT1 : RING_ROT3;
        end else begin
          w_ring_op = RING_ROT2;
        end
        if (!en) begin
          w_state_nxt = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (en) begin
          w_ring_op   = RING_ROT2;
          w_state_nxt = ST_RUN;
        end else if (w_rise_on_rot2) begin
          w_ring_op   = RING_CLEAR;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ring_op = RING_ROT2;
        end
      end
      default: begin
        w_ring_op   = RING_CLEAR;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign running = (r_state != ST_IDLE);

`ifdef DVI_CLOCK_GEN_PHASE_ADJ_EN
  localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(RATIO - 1);
  localparam logic [PH_W-1:0] COOL_LOAD = PH_W'(RATIO / 2);

  logic [PH_W-1:0] r_offset;
  logic [PH_W-1:0] r_cool;

  // A step is taken only while running and outside the cooldown window;
  // requests at other times are dropped, not queued.
  assign w_accept = phase_step & (r_state == ST_RUN) & (r_cool == '0);
  assign w_dir    = phase_dir;

  // Cumulative phase offset in bits, modulo RATIO; restarts at each start.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_offset <= '0;
    end else if ((r_state == ST_IDLE) && en) begin
      r_offset <= '0;
    end else if (w_accept) begin
      if (phase_dir) begin
        r_offset <= (r_offset == OFF_LAST) ? '0 : r_offset + PH_W'(1);
      end else begin
        r_offset <= (r_offset == '0) ? OFF_LAST : r_offset - PH_W'(1);
      end
    end
  end

  // One-pixel cooldown after each step; dropped whenever RUN is left.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_cool <= '0;
    end else if (w_state_nxt != ST_RUN) begin
      r_cool <= '0;
    end else if (w_accept) begin
      r_cool <= COOL_LOAD;
    end else if (r_cool != '0) begin
      r_cool <= r_cool - PH_W'(1);
    end
  end

  assign phase_busy   = (r_cool != '0);
  assign phase_offset = r_offset;
`else
  logic w_unused_phase;

  assign w_accept       = 1'b0;
  assign w_dir          = 1'b0;
  assign w_unused_phase = phase_step ^ phase_dir;
  assign phase_busy     = 1'b0;
  assign phase_offset   = '0;
`endif

  dvi_clock_ring #(
    .RATIO(RATIO)
  ) u_ring (
    .clk_x5         (clk_x5),
    .rst_n_x5       (rst_n_x5),
    .i_op           (w_ring_op),
    .o_bit0         (w_bit0),
    .o_bit1         (w_bit1),
    .o_pix_start    (pix_start),
    .o_rise_on_rot2 (w_rise_on_rot2)
  );

  // Every pair shares the ring; the negative leg is the bitwise complement.
  for (genvar g = 0; g < N_CLK; g++) begin : g_pair
    ddr_out u_ddr_p (
      .i_clk    (clk_x5),
      .i_rst_n  (rst_n_x5),
      .i_e      (1'b1),
      .i_d_rise (w_bit0),
      .i_d_fall (w_bit1),
      .o_q      (qp[g])
    );
    ddr_out u_ddr_n (
      .i_clk    (clk_x5),
      .i_rst_n  (rst_n_x5),
      .i_e      (1'b1),
      .i_d_rise (~w_bit0),
      .i_d_fall (~w_bit1),
      .o_q      (qn[g])
    );
  end

endmodule

// File: tb/tb_dvi_clock_gen.sv
// Testbench for dvi_clock_gen: a RATIO=10 single-pair instance checked every
// half-cycle against a bit-position model through a scoreboard, plus a
// RATIO=4, N_CLK=3 instance checked by its own scenario task.
module tb_dvi_clock_gen;

  localparam int RA  = 10;
  localparam int PW  = 5;
  localparam int RB  = 4;
  localparam int NB  = 3;
  localparam int PWB = 3;
`ifdef DVI_CLOCK_GEN_PHASE_ADJ_EN
  localparam bit PHASE_ON = 1'b1;
`else
  localparam bit PHASE_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic          en_a = 1'b0, step_a = 1'b0, dir_a = 1'b0;
  logic          running_a, pix_a, busy_a;
  logic [PW-1:0] off_a;
  logic [0:0]    qp_a, qn_a;

  logic           en_b = 1'b0, step_b = 1'b0, dir_b = 1'b0;
  logic           running_b, pix_b, busy_b;
  logic [PWB-1:0] off_b;
  logic [NB-1:0]  qp_b, qn_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic b0; logic b1; } bits_t;
  typedef struct packed { logic pix; logic run; logic busy; logic [PW-1:0] off; } ctl_t;

  bits_t q_bit[$];
  ctl_t  q_ctl[$];
  bit    sb_on = 1'b0;

  // model: 0 idle, 1 run, 2 stopping; m_p = pattern index of ring bit 0
  int m_state = 0, m_p = 0, m_cool = 0, m_off = 0;

  always #5 clk = ~clk;

  dvi_clock_gen #(.RATIO(RA), .N_CLK(1), .PH_W(PW)) dut_a (
    .clk_x5(clk), .rst_n_x5(rst_n), .en(en_a), .running(running_a),
    .pix_start(pix_a), .phase_step(step_a), .phase_dir(dir_a),
    .phase_busy(busy_a), .phase_offset(off_a), .qp(qp_a), .qn(qn_a)
  );

  dvi_clock_gen #(.RATIO(RB), .N_CLK(NB), .PH_W(PWB)) dut_b (
    .clk_x5(clk), .rst_n_x5(rst_n), .en(en_b), .running(running_b),
    .pix_start(pix_b), .phase_step(step_b), .phase_dir(dir_b),
    .phase_busy(busy_b), .phase_offset(off_b), .qp(qp_b), .qn(qn_b)
  );

  function automatic logic pat(input int x);
    return ((x % RA) < (RA / 2));
  endfunction

  // Advance the model by one clock and push the expected outputs.
  task automatic model_step(input logic en, input logic st, input logic dir);
    logic  prev;
    bit    acc;
    int    k;
    int    np;
    bits_t b;
    ctl_t  c;
    prev = (m_state == 0) ? 1'b0 : pat(m_p + 1);
    case (m_state)
      0: begin
        if (en) begin
          m_state = 1; m_p = 0; m_off = 0; m_cool = 0;
        end
      end
      1: begin
        acc = PHASE_ON && st && (m_cool == 0);
        k = acc ? (dir ? 1 : 3) : 2;
        m_p = (m_p + k) % RA;
        if (acc) m_off = dir ? (m_off + 1) % RA : (m_off + RA - 1) % RA;
        if (acc) m_cool = RA / 2;
        else if (m_cool > 0) m_cool = m_cool - 1;
        if (!en) begin
          m_state = 2; m_cool = 0;
        end
      end
      default: begin
        np = (m_p + 2) % RA;
        if (en) begin
          m_state = 1; m_p = np;
        end else if ((!prev && pat(np)) || (!pat(np) && pat(np + 1))) begin
          m_state = 0;
        end else begin
          m_p = np;
        end
      end
    endcase
    if (m_state == 0) begin
      b = '0;
      c.pix = 1'b0;
    end else begin
      b.b0 = pat(m_p);
      b.b1 = pat(m_p + 1);
      c.pix = (!prev && b.b0) || (!b.b0 && b.b1);
    end
    c.run  = (m_state != 0);
    c.busy = (m_cool != 0);
    c.off  = PW'(m_off);
    q_bit.push_back(b);
    q_ctl.push_back(c);
  endtask

  task automatic drive_cycle(input logic en, input logic st, input logic dir);
    en_a = en; step_a = st; dir_a = dir;
    model_step(en, st, dir);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: pop and compare DUT A outputs on both clock halves.
  initial begin : monitor
    bits_t b;
    ctl_t  c;
    bit    have;
    forever begin
      @(posedge clk);
      #1;
      have = 1'b0;
      if (sb_on) begin
        n_tests++;
        if (q_ctl.size() == 0 || q_bit.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty t=%0t ctl=%0d bit=%0d required nonzero", $time, q_ctl.size(), q_bit.size());
        end else begin
          c = q_ctl.pop_front();
          b = q_bit.pop_front();
          have = 1'b1;
          if ({pix_a, running_a, busy_a, off_a} !== c) begin
            n_fail++;
            $display("FAIL ctl t=%0t got pix=%b run=%b busy=%b off=%0d required pix=%b run=%b busy=%b off=%0d",
                     $time, pix_a, running_a, busy_a, off_a, c.pix, c.run, c.busy, c.off);
          end
          n_tests++;
          if (qp_a[0] !== b.b0 || qn_a[0] !== ~b.b0) begin
            n_fail++;
            $display("FAIL q_rise t=%0t got qp=%b qn=%b required qp=%b qn=%b", $time, qp_a[0], qn_a[0], b.b0, ~b.b0);
          end
        end
      end
      @(negedge clk);
      #1;
      if (have) begin
        n_tests++;
        if (qp_a[0] !== b.b1 || qn_a[0] !== ~b.b1) begin
          n_fail++;
          $display("FAIL q_fall t=%0t got qp=%b qn=%b required qp=%b qn=%b", $time, qp_a[0], qn_a[0], b.b1, ~b.b1);
        end
      end
    end
  end

  task automatic test_reset();
    bit pix_seen;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (running_a !== 1'b0 || pix_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctl got run=%b pix=%b required 0 0", running_a, pix_a);
    end
    n_tests++;
    if (qp_a[0] !== 1'b0 || qn_a[0] !== 1'b0 || qp_b !== '0 || qn_b !== '0) begin
      n_fail++;
      $display("FAIL rst_q got qp=%b qn=%b qp_b=%b qn_b=%b required all 0", qp_a, qn_a, qp_b, qn_b);
    end
    n_tests++;
    if (busy_a !== 1'b0 || off_a !== '0) begin
      n_fail++;
      $display("FAIL rst_phase got busy=%b off=%0d required 0 0", busy_a, off_a);
    end
    #10;
    rst_n = 1'b1;
    q_bit.push_back('0);
    sb_on = 1'b1;
    pix_seen = 1'b0;
    repeat (20) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (pix_a !== 1'b0) pix_seen = 1'b1;
    end
    n_tests++;
    if (pix_seen !== 1'b0 || qn_a[0] !== 1'b1 || running_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got pix_seen=%b qn=%b run=%b required 0 1 0", pix_seen, qn_a[0], running_a);
    end
  endtask

  task automatic test_run();
    int pix_cnt;
    pix_cnt = 0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (running_a !== 1'b1) begin
      n_fail++;
      $display("FAIL run_after_en got %b required 1", running_a);
    end
    if (pix_a === 1'b1) pix_cnt++;
    repeat (19) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      if (pix_a === 1'b1) pix_cnt++;
    end
    n_tests++;
    if (pix_cnt != 4) begin
      n_fail++;
      $display("FAIL pix_count got %0d required 4", pix_cnt);
    end
  endtask

  task automatic test_stop();
    int  n_stop;
    bit  dropped;
    n_stop = 0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (running_a === 1'b0 && n_stop == 0) n_stop = i;
    end
    n_tests++;
    if (n_stop != 4) begin
      n_fail++;
      $display("FAIL stop_cycles got %0d required 4", n_stop);
    end
    dropped = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    if (running_a !== 1'b1) dropped = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0);
    if (running_a !== 1'b1) dropped = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (dropped !== 1'b0 || running_a !== 1'b1 || pix_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_resume got dropped=%b run=%b pix=%b required 0 1 1", dropped, running_a, pix_a);
    end
    repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic go_idle_a();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (running_a === 1'b0) idle = 1'b1;
    end
    n_tests++;
    if (!idle) begin
      n_fail++;
      $display("FAIL go_idle running=%b required 0 within 12 cycles", running_a);
    end
  endtask

`ifdef DVI_CLOCK_GEN_PHASE_ADJ_EN
  task automatic test_phase();
    int busy_cnt;
    go_idle_a();
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1);
      n_tests++;
      if (off_a !== PW'(i) || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL retard_%0d got off=%0d busy=%b required off=%0d busy=1", i, off_a, busy_a, i);
      end
      busy_cnt = 1;
      repeat (6) begin
        drive_cycle(1'b1, 1'b0, 1'b0);
        if (busy_a === 1'b1) busy_cnt++;
      end
      n_tests++;
      if (busy_cnt != RA / 2) begin
        n_fail++;
        $display("FAIL busy_len_%0d got %0d required %0d", i, busy_cnt, RA / 2);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (off_a !== PW'(4)) begin
      n_fail++;
      $display("FAIL step_while_busy got off=%0d required 4", off_a);
    end
    go_idle_a();
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (off_a !== PW'(9)) begin
      n_fail++;
      $display("FAIL advance_wrap got off=%0d required 9", off_a);
    end
    repeat (8) drive_cycle(1'b1, 1'b0, 1'b0);
  endtask
`else
  task automatic test_phase();
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (off_a !== '0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL phase_ignored got off=%0d busy=%b required 0 0", off_a, busy_a);
    end
    repeat (6) drive_cycle(1'b1, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_small();
    logic exp;
    bit   idle;
    en_b = 1'b1;
    step_b = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (pix_b !== 1'b1 || running_b !== 1'b1) begin
      n_fail++;
      $display("FAIL small_start got pix=%b run=%b required 1 1", pix_b, running_b);
    end
    for (int i = 1; i <= 8; i++) begin
      step_b = !PHASE_ON && (i % 3 == 1);
      dir_b  = (i % 2 == 0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp = (i % 2 == 1);
      n_tests++;
      if (qp_b !== {NB{exp}} || qn_b !== {NB{~exp}} || pix_b !== !exp) begin
        n_fail++;
        $display("FAIL small_rise_%0d got qp=%b qn=%b pix=%b required qp=%b qn=%b pix=%b",
                 i, qp_b, qn_b, pix_b, {NB{exp}}, {NB{~exp}}, !exp);
      end
      n_tests++;
      if (busy_b !== 1'b0 || off_b !== '0) begin
        n_fail++;
        $display("FAIL small_phase_%0d got busy=%b off=%0d required 0 0", i, busy_b, off_b);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (qp_b !== {NB{exp}} || qn_b !== {NB{~exp}}) begin
        n_fail++;
        $display("FAIL small_fall_%0d got qp=%b qn=%b required qp=%b qn=%b", i, qp_b, qn_b, {NB{exp}}, {NB{~exp}});
      end
    end
    step_b = 1'b0;
    en_b = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (running_b === 1'b0) idle = 1'b1;
    end
    n_tests++;
    if (!idle || qp_b !== '0 || qn_b !== {NB{1'b1}}) begin
      n_fail++;
      $display("FAIL small_stop got idle=%b qp=%b qn=%b required 1 000 111", idle, qp_b, qn_b);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop();
    test_phase();
    test_small();
    drive_cycle(1'b0, 1'b0, 1'b0);
    sb_on = 1'b0;
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
